calc_sequencer: RTL
===================

# calc_sequencer

Top-level operation sequencer for the matrix calculator. It accepts one command at a time (operation type plus manual/random mode), drives the operand selector through a start/done/error handshake, and launches the compute unit with the chosen matrix IDs. It guards every wait with a watchdog and reports a result or error code to the UI layer. It sits between the UI/key decoder and the operand selector / compute datapath.

## Interface
- `TIMEOUT`, default 1024: watchdog limit in cycles for each wait state (minimum 4).
- `ERR_HOLD`, default 16: number of cycles the error state is held before returning to IDLE.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: operation type. 0 transpose, 1 add, 2 scalar, 3 multiply, 4 conv.
- `cmd_manual` in 1: 1 = manual operand entry, 0 = random.
- `abort` in 1: cancel the current command.
- `sel_start` out 1, `sel_manual` out 1, `sel_op` out 3: selector control.
- `sel_done` in 1, `sel_error` in 1, `sel_a` in 4, `sel_b` in 4: selector results.
- `alu_start` out 1, `alu_op` out 3, `alu_id_a` out 4, `alu_id_b` out 4: compute launch.
- `alu_done` in 1, `alu_error` in 1: compute completion.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: one-cycle success pulse.
- `err_code` out 2: 0 none, 1 select, 2 alu, 3 timeout/abort.
- `op_count` out 8: successful operations, wraps from 255 to 0.
- `err_count` out 8: failed operations, saturates at 255.

## Operation
- States: IDLE, SEL_CLR, SEL_GAP, SEL_START, SEL_WAIT, EXEC_START, EXEC_WAIT, RESULT, ERROR.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_op` and `cmd_manual` into `sel_op`, `sel_manual` and `alu_op`.
  - If `sel_error`=1 (selector parked in its error state), go to SEL_CLR; otherwise go to SEL_START.
- SEL_CLR: `sel_start`=1 for 1 cycle (recovery pulse), then SEL_GAP.
- SEL_GAP: 2 cycles, then SEL_START.
- SEL_START: `sel_start`=1 for 1 cycle, clear the watchdog, then SEL_WAIT.
- SEL_WAIT:
  - `sel_done`/`sel_error` are ignored in the first 2 cycles (blanking).
  - After blanking, `sel_error` → ERROR with code 1. `sel_error` has priority over `sel_done` if both are high.
  - `sel_done` → latch `sel_a` and `sel_b` into `alu_id_a` and `alu_id_b`, then go to EXEC_START.
- EXEC_START: `alu_start`=1 for 1 cycle, clear the watchdog, then EXEC_WAIT.
- EXEC_WAIT:
  - `alu_error` → ERROR with code 2.
  - `alu_done` → RESULT.
  - `alu_error` has priority over `alu_done`.
- RESULT: `result_valid`=1 for 1 cycle, `op_count`+1, then IDLE.
- ERROR:
  - `err_code` is held for ERR_HOLD cycles, then the block returns to IDLE with `err_code`=0.
  - `err_count` is incremented once, on entry.
- Watchdog: reaching TIMEOUT in SEL_WAIT or EXEC_WAIT → ERROR with code 3.
- `abort`: in any busy state except ERROR → ERROR with code 3 on the next edge. Abort has priority over every other event. It is ignored in IDLE and ERROR.
- `cmd_valid` while busy is ignored (`cmd_ready`=0); the command is not queued.

## Timing
- Reset values of all outputs:
  - 0: `cmd_ready`, `busy`, `sel_start`, `alu_start`, `result_valid`, all IDs, `alu_op`, `sel_op`, `sel_manual`, both counters, `err_code`.
  - State = IDLE. `cmd_ready` goes to 1 in the first cycle after reset release.
- Accept at edge T (clean selector):
  - `sel_start` high during cycle T+1.
  - Earliest `sel_done` sampled at T+4.
  - `alu_start` one cycle after `sel_done` is sampled.
  - `result_valid` one cycle after `alu_done` is sampled.
- Recovery path (SEL_CLR + SEL_GAP) adds 3 cycles.
- All outputs are registered. `sel_start`, `alu_start` and `result_valid` are never high for more than 1 consecutive cycle.
- Asynchronous reset mid-operation: everything returns to reset values immediately and no pulse is emitted.

## Structure
- Shared package `calc_pkg`: op-type constants (OP_TRANSPOSE..OP_CONV), err_code constants, state enum.
- One sub-module, `watchdog_timer`, with inputs clear/enable and an expired output, parameterised by TIMEOUT.
- Counters and the FSM stay in the top module.

## Test plan
- Clean selector, `cmd_op`=3, selector returns `sel_done` with `sel_a`=2, `sel_b`=5, then `alu_done` → `alu_start` with `alu_id_a`=2, `alu_id_b`=5, `alu_op`=3; then `result_valid` for 1 cycle; `op_count`=1.
- `sel_error` held high at accept → one recovery `sel_start` pulse, 2-cycle gap, second `sel_start` pulse; a `sel_error` glitch inside the blanking window is ignored.
- `sel_error` after blanking → `err_code`=1 for exactly 16 cycles, `err_count`=1, back to IDLE, `alu_start` never asserted.
- `alu_done` never arrives, TIMEOUT=8 → ERROR with `err_code`=3 after 8 EXEC_WAIT cycles; `alu_error` and `alu_done` asserted together instead → `err_code`=2.
- `abort` in SEL_WAIT → `err_code`=3 on the next cycle; `cmd_valid` during busy is ignored; 256 successes → `op_count` wraps to 0.
- Reset asserted in EXEC_WAIT → all outputs 0 at once; after release, `cmd_ready`=1 and no stale `result_valid`.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the matrix calculator sequencer.
package calc_pkg;

    localparam logic [2:0] OP_TRANSPOSE = 3'd0;
    localparam logic [2:0] OP_ADD       = 3'd1;
    localparam logic [2:0] OP_SCALAR    = 3'd2;
    localparam logic [2:0] OP_MULTIPLY  = 3'd3;
    localparam logic [2:0] OP_CONV      = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SEL     = 2'd1;
    localparam logic [1:0] ERR_ALU     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL_CLR,
        S_SEL_GAP,
        S_SEL_START,
        S_SEL_WAIT,
        S_EXEC_START,
        S_EXEC_WAIT,
        S_RESULT,
        S_ERROR
    } state_t;

endpackage

// File: rtl/watchdog_timer.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the TIMEOUT-th enabled cycle completes.
module watchdog_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// Operation sequencer: takes one command, runs the operand selector and then
// the compute unit, and reports a result pulse or an error code to the UI.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT  = 1024,
    parameter int ERR_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_manual,
    input  logic       abort,
    output logic       sel_start,
    output logic       sel_manual,
    output logic [2:0] sel_op,
    input  logic       sel_done,
    input  logic       sel_error,
    input  logic [3:0] sel_a,
    input  logic [3:0] sel_b,
    output logic       alu_start,
    output logic [2:0] alu_op,
    output logic [3:0] alu_id_a,
    output logic [3:0] alu_id_b,
    input  logic       alu_done,
    input  logic       alu_error,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] err_code,
    output logic [7:0] op_count,
    output logic [7:0] err_count
);

    localparam int HOLD_W = $clog2(ERR_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ERR_HOLD - 1);

    state_t            state;
    logic [1:0]        aux_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expired;
    logic              err_hit;
    logic [1:0]        err_val;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wd_clear  = (state == S_SEL_START) || (state == S_EXEC_START);
    assign wd_enable = (state == S_SEL_WAIT) || (state == S_EXEC_WAIT);

    watchdog_timer #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Abort outranks everything; in SEL_WAIT the blanking counter gates the selector.
    always_comb begin
        err_hit = 1'b0;
        err_val = ERR_NONE;
        if (abort && state != S_IDLE && state != S_ERROR) begin
            err_hit = 1'b1;
            err_val = ERR_TIMEOUT;
        end else if (state == S_SEL_WAIT && aux_cnt == 2'd2) begin
            if (sel_error) begin
                err_hit = 1'b1;
                err_val = ERR_SEL;
            end else if (!sel_done && wd_expired) begin
                err_hit = 1'b1;
                err_val = ERR_TIMEOUT;
            end
        end else if (state == S_EXEC_WAIT) begin
            if (alu_error) begin
                err_hit = 1'b1;
                err_val = ERR_ALU;
            end else if (!alu_done && wd_expired) begin
                err_hit = 1'b1;
                err_val = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            aux_cnt      <= '0;
            hold_cnt     <= '0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            sel_start    <= 1'b0;
            sel_manual   <= 1'b0;
            sel_op       <= '0;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            alu_id_a     <= '0;
            alu_id_b     <= '0;
            result_valid <= 1'b0;
            err_code     <= ERR_NONE;
            op_count     <= '0;
            err_count    <= '0;
        end else begin
            sel_start    <= 1'b0;
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
            if (err_hit) begin
                state     <= S_ERROR;
                err_code  <= err_val;
                err_count <= sat_inc(err_count);
                hold_cnt  <= '0;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        if (cmd_valid && cmd_ready) begin
                            sel_op     <= cmd_op;
                            alu_op     <= cmd_op;
                            sel_manual <= cmd_manual;
                            cmd_ready  <= 1'b0;
                            busy       <= 1'b1;
                            sel_start  <= 1'b1;
                            // A selector parked in error gets a recovery pulse first.
                            state      <= sel_error ? S_SEL_CLR : S_SEL_START;
                        end
                    end
                    S_SEL_CLR: begin
                        aux_cnt <= '0;
                        state   <= S_SEL_GAP;
                    end
                    S_SEL_GAP: begin
                        if (aux_cnt == 2'd1) begin
                            sel_start <= 1'b1;
                            state     <= S_SEL_START;
                        end else begin
                            aux_cnt <= aux_cnt + 2'd1;
                        end
                    end
                    S_SEL_START: begin
                        aux_cnt <= '0;
                        state   <= S_SEL_WAIT;
                    end
                    S_SEL_WAIT: begin
                        if (aux_cnt != 2'd2) begin
                            aux_cnt <= aux_cnt + 2'd1;
                        end else if (sel_done) begin
                            alu_id_a  <= sel_a;
                            alu_id_b  <= sel_b;
                            alu_start <= 1'b1;
                            state     <= S_EXEC_START;
                        end
                    end
                    S_EXEC_START: begin
                        state <= S_EXEC_WAIT;
                    end
                    S_EXEC_WAIT: begin
                        if (alu_done) begin
                            result_valid <= 1'b1;
                            op_count     <= op_count + 8'd1;
                            state        <= S_RESULT;
                        end
                    end
                    S_RESULT: begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    S_ERROR: begin
                        if (hold_cnt == HOLD_LAST) begin
                            err_code  <= ERR_NONE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
